// File: rtl/stopwatch_cu.sv
// stopwatch_cu: conditions the raw buttons and switch, then runs the RUN/STOP/CLEAR control FSM.
// Define STOPWATCH_LAP_EN to build the lap button path and the o_lap_hold toggle.
module stopwatch_cu #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int SAMPLE_HZ  = 100_000,
  parameter int DB_SAMPLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnL_RunStop,
  input  logic       btnR_Clear,
  input  logic       btnU_Lap,
  input  logic       sw0,
  output logic       o_run,
  output logic       o_clear,
  output logic       o_disp_sel,
  output logic       o_lap_hold,
  output logic [1:0] o_state
);

  localparam int TICK_DIV = CLK_FREQ / SAMPLE_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef STOPWATCH_LAP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  logic [NB-1:0]    w_raw;
  logic [NB-1:0]    w_pulse;
  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_tick;
  logic             w_rs_p;
  logic             w_clr_p;
  logic             r_sw_s1;
  logic             r_sw_s2;
  state_t           r_state;
  logic             r_run;
  logic             r_clear;
  logic [1:0]       r_state_out;

`ifdef STOPWATCH_LAP_EN
  logic w_lap_p;
  logic r_lap_hold;
  assign w_raw      = {btnU_Lap, btnR_Clear, btnL_RunStop};
  assign w_lap_p    = w_pulse[2];
  assign o_lap_hold = r_lap_hold;
`else
  logic w_unused_lap;
  assign w_raw        = {btnR_Clear, btnL_RunStop};
  assign w_unused_lap = btnU_Lap;
  assign o_lap_hold   = 1'b0;
`endif

  assign w_rs_p  = w_pulse[0];
  assign w_clr_p = w_pulse[1];

  // Shared sampling strobe for all debouncers.
  assign w_tick = (r_tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_s1 <= 1'b0;
      r_sw_s2 <= 1'b0;
    end else begin
      r_sw_s1 <= sw0;
      r_sw_s2 <= r_sw_s1;
    end
  end

  assign o_disp_sel = r_sw_s2;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_btn
      logic                  r_s1;
      logic                  r_s2;
      logic                  r_db;
      logic                  r_db_d;
      logic [DB_SAMPLES-1:0] r_sh;
      logic [DB_SAMPLES-1:0] w_sh_next;

      // The level decision looks at the window including the sample being shifted in.
      assign w_sh_next = {r_sh[DB_SAMPLES-2:0], r_s2};

      always_ff @(posedge clk) begin
        if (reset) begin
          r_s1   <= 1'b0;
          r_s2   <= 1'b0;
          r_sh   <= '0;
          r_db   <= 1'b0;
          r_db_d <= 1'b0;
        end else begin
          r_s1   <= w_raw[gi];
          r_s2   <= r_s1;
          r_db_d <= r_db;
          if (w_tick) begin
            r_sh <= w_sh_next;
            if (&w_sh_next) begin
              r_db <= 1'b1;
            end else if (~|w_sh_next) begin
              r_db <= 1'b0;
            end
          end
        end
      end

      assign w_pulse[gi] = r_db & ~r_db_d;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_STOP;
      r_run       <= 1'b0;
      r_clear     <= 1'b0;
      r_state_out <= 2'b00;
`ifdef STOPWATCH_LAP_EN
      r_lap_hold  <= 1'b0;
`endif
    end else begin
      r_run       <= (r_state == ST_RUN);
      r_clear     <= (r_state == ST_CLEAR);
      r_state_out <= r_state;
      case (r_state)
        ST_STOP: begin
          if (w_rs_p) begin
            r_state <= ST_RUN;
          end else if (w_clr_p) begin
            r_state <= ST_CLEAR;
          end
        end
        ST_RUN: begin
          if (w_rs_p) begin
            r_state <= ST_STOP;
          end
        end
        default: r_state <= ST_STOP;
      endcase
`ifdef STOPWATCH_LAP_EN
      // Lap hold is cleared on the edge that enters CLEAR; lap presses in CLEAR are dropped.
      if (r_state == ST_STOP && !w_rs_p && w_clr_p) begin
        r_lap_hold <= 1'b0;
      end else if (w_lap_p && r_state == ST_RUN) begin
        r_lap_hold <= ~r_lap_hold;
      end else if (w_lap_p && r_state == ST_STOP) begin
        r_lap_hold <= 1'b0;
      end
`endif
    end
  end

  assign o_run   = r_run;
  assign o_clear = r_clear;
  assign o_state = r_state_out;

endmodule

// File: doc/stopwatch_cu.md
# stopwatch_cu

Control unit for the stopwatch: conditions the raw board buttons and switch, runs the RUN/STOP/CLEAR state machine, and drives the run/clear controls of the stopwatch counter datapath and the display-mode select of the FND controller. Sits between the board pins and the stopwatch datapath inside the `stopwatch` top, replacing ad-hoc button handling.

## Interface

Parameters:
- `CLK_FREQ`, 100_000_000: system clock frequency, Hz.
- `SAMPLE_HZ`, 100_000: debounce sampling rate, Hz; `TICK_DIV = CLK_FREQ / SAMPLE_HZ`, must be at least 2.
- `DB_SAMPLES`, 8: consecutive equal samples required to change a debounced level, 2..16.

Ports:
- `clk` in 1: system clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `btnL_RunStop` in 1: raw run/stop button, asynchronous, active-high.
- `btnR_Clear` in 1: raw clear button, asynchronous, active-high.
- `btnU_Lap` in 1: raw lap button; ignored unless the lap feature is compiled in.
- `sw0` in 1: raw display-mode switch.
- `o_run` out 1: datapath count enable, 1 in RUN.
- `o_clear` out 1: datapath synchronous clear, 1 for exactly one cycle per clear.
- `o_disp_sel` out 1: synchronized `sw0`, selects the FND display mode.
- `o_lap_hold` out 1: 1 = FND shows the frozen lap value.
- `o_state` out 2: 00 STOP, 01 RUN, 10 CLEAR; 11 is never produced.

## Operation

- Synchronization: all four raw inputs pass through two flops. `o_disp_sel` is the second flop of `sw0` and has no debounce.
- Tick: a counter runs 0..TICK_DIV-1 and wraps. The tick is 1 for the single cycle where count == TICK_DIV-1.
- Debounce, per button: on each tick, shift the synchronized level into a DB_SAMPLES-bit register.
  - All ones: the debounced level becomes 1.
  - All zeros: the debounced level becomes 0.
  - Otherwise: the debounced level holds.
- Edge detect: a 0→1 transition of a debounced level gives a one-cycle pulse (`rs_p`, `clr_p`, `lap_p`). Releases and level changes with no transition give no pulse.
- FSM:
  - STOP: `rs_p` → RUN. Otherwise `clr_p` → CLEAR. If both pulses arrive in the same cycle, run/stop wins and the clear is dropped.
  - RUN: `rs_p` → STOP. `clr_p` is ignored.
  - CLEAR: lasts exactly one cycle, then → STOP unconditionally. Pulses arriving in CLEAR are dropped.
- Outputs are registered and decoded from the state: `o_run` = (state == RUN), `o_clear` = (state == CLEAR).
- Reset: state = STOP; tick counter, shift registers, debounced levels and edge history = 0; all outputs 0.
  - Reset asserted mid-RUN forces STOP on the next edge with no clear pulse.
  - A button still held when reset is released produces one pulse once the debounce is satisfied.

## Timing

- Press-to-pulse latency: 2 sync cycles + at most DB_SAMPLES × TICK_DIV cycles + 1 edge cycle. With the defaults this is at most 8003 cycles (80.03 µs).
- Pulse-to-output: the FSM register and the output register each add one cycle. `o_run` changes, or `o_clear` asserts, 2 cycles after `rs_p`/`clr_p`.
- Glitches shorter than DB_SAMPLES consecutive ticks never change a debounced level.
- One press gives exactly one pulse however long it is held; a held button never auto-repeats.
- `o_disp_sel` follows `sw0` 2 cycles later.

## Configuration

- `STOPWATCH_LAP_EN` defined:
  - `lap_p` in RUN toggles `o_lap_hold`.
  - `lap_p` in STOP clears `o_lap_hold`.
  - Entering CLEAR clears `o_lap_hold`.
  - The RUN↔STOP transitions leave `o_lap_hold` unchanged.
  - `lap_p` is debounced and edge-detected the same way as the other buttons.
- `STOPWATCH_LAP_EN` undefined:
  - No lap synchronizer, debounce or edge logic is built.
  - `o_lap_hold` is tied to 0 and `btnU_Lap` is unused.

## Test plan

All scenarios use the default parameters.

- Reset, then press `btnL_RunStop` for 1 ms → `o_run` = 1 within 8005 cycles of the press and stays 1 after release, `o_state` = 01; press again for 1 ms → `o_run` = 0, `o_state` = 00.
- From STOP, press `btnR_Clear` for 1 ms → `o_clear` is 1 for exactly one cycle, `o_state` shows 10 for one cycle and then returns to 00; repeat the press in RUN → no `o_clear`, `o_run` stays 1.
- Toggle `btnL_RunStop` with 20 µs high / 20 µs low bursts for 500 µs → no state change; then hold for 1 ms → exactly one RUN transition.
- Press both buttons simultaneously (same cycle) in STOP → state becomes RUN and `o_clear` never asserts.
- `sw0` 0→1 → `o_disp_sel` = 1 two cycles later; reset asserted mid-RUN → `o_run` = 0 and all outputs 0 on the next edge, with no `o_clear`.
- With `STOPWATCH_LAP_EN`:
  - In RUN, press lap → `o_lap_hold` = 1; press lap again → 0; press lap once more → 1.
  - Stop, then clear → `o_lap_hold` = 0.
- Without `STOPWATCH_LAP_EN`: press lap → `o_lap_hold` stays 0.
